// File: rtl/mem_branch_pkg.sv
// Shared constants for the memory/branch stage.
// Holds op encodings, FSM states and the alignment helper.
package mem_branch_pkg;

  localparam logic [1:0] ALU_A_RS1 = 2'd0;
  localparam logic [1:0] ALU_A_PC  = 2'd1;
  localparam logic [1:0] ALU_B_RS2 = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;

  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [1:0] BRANCH_OP_NONE = 2'd0;
  localparam logic [1:0] BRANCH_OP_EQ   = 2'd1;
  localparam logic [1:0] BRANCH_OP_NE   = 2'd2;
  localparam logic [1:0] BRANCH_OP_JUMP = 2'd3;

  typedef enum logic {
    MB_IDLE = 1'b0,
    MB_BUS  = 1'b1
  } mb_state_e;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b1;
    if (size == MEM_SIZE_HALF) ok = (off[0] == 1'b0);
    if (size == MEM_SIZE_WORD) ok = (off == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/mem_branch_lane.sv
// Byte-lane steering: store strobes/replication and
// load extraction with sign or zero extension.
module mem_lane
  import mem_branch_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata[{off, 3'b000} +: 8];
    half_v  = off[1] ? rdata[31:16] : rdata[15:0];
    wstrb   = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        wstrb   = 4'b0001 << off;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{!uns && byte_v[7]}}, byte_v};
      end
      MEM_SIZE_HALF: begin
        wstrb   = off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{!uns && half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_branch.sv
// Memory/branch pipeline stage: branch resolution,
// data-memory handshake with stall and bus timeout.
module mem_branch
  import mem_branch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__alu_y,
  input  logic        ex_mb__alu_zero,
  input  logic [31:0] ex_mb__pc_4,
  input  logic [31:0] ex_mb__target,
  input  logic [31:0] ex_mb__rs2_rdata,
  input  logic [1:0]  ex_mb__mem_op,
  input  logic [1:0]  ex_mb__mem_size,
  input  logic        ex_mb__mem_unsigned,
  input  logic [1:0]  ex_mb__branch_op,
  input  logic [4:0]  ex_mb__rd_addr,
  input  logic        ex_mb__rd_wen,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mb_stall,
  output logic        pipe_flush,
  output logic [31:0] branch_pc,
  output logic [4:0]  mb_wb__rd_addr,
  output logic        mb_wb__rd_wen,
  output logic [31:0] mb_wb__rd_wdata,
  output logic        mb_misaligned,
  output logic        mb_bus_error
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  mb_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_wen_q, rd_wen_d;
  logic [31:0] rd_wdata_q, rd_wdata_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic        mem_active;
  logic        aligned;
  logic        is_bus;
  logic        timeout;
  logic        misaligned;
  logic        is_load;
  logic        is_store;
  logic        take;
  logic [31:0] ld_data;

  mem_lane u_lane (
    .size    (ex_mb__mem_size),
    .uns     (ex_mb__mem_unsigned),
    .off     (ex_mb__alu_y[1:0]),
    .st_data (ex_mb__rs2_rdata),
    .rdata   (dmem_rdata),
    .wstrb   (dmem_wstrb),
    .wdata   (dmem_wdata),
    .ld_data (ld_data)
  );

  always_comb begin
    mem_active = ex_mb__valid
              && (ex_mb__mem_op != MEM_OP_NONE);
    is_load    = mem_active
              && (ex_mb__mem_op == MEM_OP_LOAD);
    is_store   = mem_active
              && (ex_mb__mem_op == MEM_OP_STORE);
    aligned    = is_aligned(ex_mb__mem_size,
                            ex_mb__alu_y[1:0]);
    misaligned = mem_active && !aligned;
    is_bus     = (state_q == MB_BUS);
    timeout    = is_bus && !dmem_ready
              && (cnt_q == TO_LIM);
    // Gate with rst so the request drops the instant reset hits.
    dmem_req   = !rst
              && ((!is_bus && mem_active && aligned) || is_bus);
    mb_stall   = dmem_req && !dmem_ready && !timeout;
    dmem_we    = is_store;
    dmem_addr  = {ex_mb__alu_y[31:2], 2'b00};

    take = 1'b0;
    case (ex_mb__branch_op)
      BRANCH_OP_EQ:   take = ex_mb__alu_zero;
      BRANCH_OP_NE:   take = !ex_mb__alu_zero;
      BRANCH_OP_JUMP: take = 1'b1;
      default:        take = 1'b0;
    endcase
    pipe_flush = ex_mb__valid && !mem_active && take;
    branch_pc  = ex_mb__target;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (is_bus) begin
      if (dmem_ready || timeout) begin
        state_d = MB_IDLE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (mem_active && aligned && !dmem_ready) begin
      state_d = MB_BUS;
      cnt_d   = 8'd1;
    end

    rd_addr_d  = mb_stall ? rd_addr_q : ex_mb__rd_addr;
    rd_wdata_d = rd_wdata_q;
    if (!mb_stall) begin
      if (is_load)
        rd_wdata_d = ld_data;
      else if (ex_mb__branch_op == BRANCH_OP_JUMP)
        rd_wdata_d = ex_mb__pc_4;
      else
        rd_wdata_d = ex_mb__alu_y;
    end
    rd_wen_d = ex_mb__valid && ex_mb__rd_wen
            && (ex_mb__rd_addr != 5'd0)
            && !misaligned && !timeout
            && !is_store && !mb_stall;
    mis_d  = misaligned;
    berr_d = timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MB_IDLE;
      cnt_q      <= 8'd0;
      rd_addr_q  <= 5'd0;
      rd_wen_q   <= 1'b0;
      rd_wdata_q <= 32'd0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_wen_q   <= rd_wen_d;
      rd_wdata_q <= rd_wdata_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign mb_wb__rd_addr  = rd_addr_q;
  assign mb_wb__rd_wen   = rd_wen_q;
  assign mb_wb__rd_wdata = rd_wdata_q;
  assign mb_misaligned   = mis_q;
  assign mb_bus_error    = berr_q;

endmodule

// File: doc/mem_branch.md
Name: mem_branch

Overview:
- Memory/branch ("mb") pipeline stage; consumes the ex_mb__ register set and produces the mb_wb__ register set.
- Resolves branches from the ALU zero flag and drives pipe_flush back to the fetch, decode and execute stages.
- Performs byte, halfword and word loads and stores over a req/ready data-memory handshake, with stall generation and a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles after the first request cycle before a bus error is declared (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_mb__valid  in  1  slot holds a real instruction (0 = bubble)
- ex_mb__alu_y  in  32  ALU result: address for load/store, rd data otherwise
- ex_mb__alu_zero  in  1  ALU zero flag
- ex_mb__pc_4  in  32  link value for jumps
- ex_mb__target  in  32  branch/jump target
- ex_mb__rs2_rdata  in  32  store data, already forwarded
- ex_mb__mem_op  in  2  NONE=0, LOAD=1, STORE=2
- ex_mb__mem_size  in  2  BYTE=0, HALF=1, WORD=2
- ex_mb__mem_unsigned  in  1  zero-extend loads
- ex_mb__branch_op  in  2  NONE=0, EQ=1 (take if zero), NE=2 (take if !zero), JUMP=3
- ex_mb__rd_addr  in  5  destination register
- ex_mb__rd_wen  in  1  destination write enable
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({alu_y[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  load word, valid when dmem_ready
- mb_stall  out  1  freeze ex_mb__ and all earlier stages
- pipe_flush  out  1  taken branch/jump
- branch_pc  out  32  redirect PC
- mb_wb__rd_addr  out  5  registered
- mb_wb__rd_wen  out  1  registered
- mb_wb__rd_wdata  out  32  registered
- mb_misaligned  out  1  registered one-cycle pulse
- mb_bus_error  out  1  registered one-cycle pulse

Behaviour:
- FSM states: IDLE and BUS. Wait counter is 8 bits.
- Reset value of all registered outputs is 0: state=IDLE, counter=0, mb_wb__*=0, mb_misaligned=0, mb_bus_error=0.
- Reset asserted mid-transaction: dmem_req drops asynchronously and nothing retires.
- mem_active = valid && mem_op != NONE.
- aligned: HALF needs alu_y[0]==0; WORD needs alu_y[1:0]==0.
- dmem_req is combinational: (IDLE && mem_active && aligned) || BUS. dmem_we, dmem_addr and dmem_wdata are driven directly from ex_mb__; they stay stable because of the stall.
- mb_stall = dmem_req && !dmem_ready && !timeout. It is 0 for non-memory ops, bubbles and misaligned ops.
- IDLE + request + dmem_ready: retire in the same cycle (zero-wait access).
- IDLE + request without ready: go to BUS, counter=1.
- BUS + dmem_ready: retire, go to IDLE, counter=0.
- BUS without ready: counter+1.
- Timeout: counter==TIMEOUT_CYCLES in BUS without ready. Retire with rd_wen=0, pulse mb_bus_error, go to IDLE.
- Retire at the posedge means mb_wb__ is loaded.
  - Load: rd_wdata = extracted lane, sign- or zero-extended.
  - Store: rd_wen=0.
- Load lane extraction: BYTE uses rdata byte alu_y[1:0]; HALF uses the halfword at alu_y[1].
- Store wstrb: BYTE 0001<<addr[1:0]; HALF 0011<<addr[1]*2; WORD 1111.
- Store wdata: BYTE {4{b}}; HALF {2{h}}; WORD rs2_rdata.
- Misaligned: no request and no stall. Retire immediately with rd_wen=0 and pulse mb_misaligned.
- Non-memory op: 1-cycle latency. rd_wdata = pc_4 if branch_op==JUMP, else alu_y.
- mb_wb__rd_wen = valid && rd_wen && rd_addr!=0 && no fault. Otherwise the stage writes a bubble: rd_wen=0.
- While mb_stall=1, mb_wb__rd_wen is 0 on every stalled edge.
- pipe_flush is combinational: valid && (JUMP || (EQ && zero) || (NE && !zero)). branch_pc = ex_mb__target.
- A memory op never carries a branch_op. If both are present, branch_op is ignored.

Decomposition:
- Shared package/header gets the MEM_OP_*, MEM_SIZE_* and BRANCH_OP_* constants and the FSM state encodings, alongside the existing ALU_A_*/ALU_B_* defines.
- One sub-module, mem_lane: store strobe/replication plus load extraction/extension, purely combinational.

Test Plan:
- LW from 0x100, rdata=0xDEADBEEF, ready held high → no stall; next edge mb_wb__rd_wdata=0xDEADBEEF, rd_wen=1.
- LB from 0x103, rdata=0x80112233, signed → 0xFFFFFF80; with mem_unsigned=1 → 0x00000080.
- SH 0x1234ABCD to 0x102, ready after 3 cycles → wstrb=1100, wdata=0xABCDABCD, mb_stall high for 3 cycles, rd_wen=0 throughout.
- LW to 0x101 → dmem_req=0, mb_stall=0, mb_misaligned pulses once, rd_wen=0.
- TIMEOUT_CYCLES=4 with ready never asserted → stall ends after 4 BUS cycles, mb_bus_error pulses once, state returns to IDLE.
- EQ branch with zero=1, target 0x200 → pipe_flush=1, branch_pc=0x200. JAL with rd=x1, pc_4=0x84 → rd_wdata=0x84. Async rst asserted during BUS → dmem_req=0 immediately, all outputs 0.
